// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the digit-serial adder.
//   state_t  : control FSM states (IDLE, RUN, DONE)
//   cnt_w(n) : width of a counter that must hold 0..n-1, never less than 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   master : producer/consumer side (drives in_valid, a, b, cin, out_ready)
//   slave  : adder side (drives in_ready, out_valid, sum, cout, busy)
// With SERIAL_ADDER_SUBTRACT_EN defined the bundle also carries sub (to the
// adder) and ovf (from the adder).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic             sub;
  logic             ovf;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, busy, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, busy, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/fa_cell.sv
// fa_cell: one-bit combinational full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds two WIDTH-bit operands plus a
// carry-in, DIGIT bits per clock through a chain of fa_cell slices, with
// the carry held in a register between cycles. Result after WIDTH/DIGIT
// cycles; one operation in flight at a time.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : serial_adder_if.slave (in_valid/in_ready, a, b, cin,
//          out_valid/out_ready, sum, cout, busy [, sub, ovf])
// Optional build macro SERIAL_ADDER_SUBTRACT_EN adds sub (a - b) and the
// signed-overflow flag ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: DIGIT must be >=1 and divide WIDTH");
  end

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;
  logic             accept, last;

  // Carry chain through the slice; c[DIGIT-1] is the carry into the MSB
  // cell, kept for the overflow flag.
  assign c[0] = carry_reg;
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    fa_cell u_fa (
      .a  (a_sh[gi]),
      .b  (b_sh[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  // New sum digits enter at the MSB end; after N steps the first digit
  // has reached bit 0.
  assign res_nx = WIDTH'({s, res} >> DIGIT);
  assign last   = (cnt == CW'(N - 1));
  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)        state_nx = RUN;
      RUN:     if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = res;
  assign bus.cout      = carry_reg;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic msb_ci;
  assign bus.ovf = (state == DONE) & (msb_ci ^ carry_reg);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
      msb_ci    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          a_sh <= bus.a;
          cnt  <= '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
          // two's complement subtract: a + ~b + 1
          b_sh      <= bus.sub ? ~bus.b : bus.b;
          carry_reg <= bus.sub ? 1'b1 : bus.cin;
`else
          b_sh      <= bus.b;
          carry_reg <= bus.cin;
`endif
        end
        RUN: begin
          a_sh      <= a_sh >> DIGIT;
          b_sh      <= b_sh >> DIGIT;
          res       <= res_nx;
          carry_reg <= c[DIGIT];
          cnt       <= cnt + CW'(1);
`ifdef SERIAL_ADDER_SUBTRACT_EN
          msb_ci    <= c[DIGIT-1];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder, one DIGIT=1 instance
// and one DIGIT=4 instance (both WIDTH=8) sharing clk/rst.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(8)) if4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

`ifdef SERIAL_ADDER_SUBTRACT_EN
  localparam logic [9:0] MASK = 10'h3FF;
`else
  localparam logic [9:0] MASK = 10'h1FF;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];  // {ovf, cout, sum}

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic s);
    logic [7:0] bb;
    logic       c0;
    logic [8:0] full;
    logic [7:0] low;
    bb   = s ? ~b : b;
    c0   = s ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, c0};
    low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, c0};
    return {low[7] ^ full[8], full};
  endfunction

  // Drives one op into dut1 starting at a negedge, returns observations.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic s, input logic poke, output int wcyc,
                          output int lat, output logic seen, output logic [9:0] got,
                          output int run_bad);
    if1.a = a; if1.b = b; if1.cin = ci; if1.in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    if1.sub = s;
`endif
    wcyc = 0; lat = 0; seen = 1'b0; got = '0; run_bad = 0;
    while (if1.in_ready !== 1'b1 && wcyc < 40) begin
      @(negedge clk); wcyc++;
    end
    if (wcyc >= 40) begin
      if1.in_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, ci, s));
    @(negedge clk);
    if1.in_valid = poke;
    if (poke) begin if1.a = ~a; if1.b = 8'h33; if1.cin = ~ci; end
    while (if1.out_valid !== 1'b1 && lat < 40) begin
      if (if1.in_ready !== 1'b0 || if1.busy !== 1'b1) run_bad++;
      @(negedge clk); lat++;
    end
    if1.in_valid = 1'b0;
    seen = (if1.out_valid === 1'b1);
`ifdef SERIAL_ADDER_SUBTRACT_EN
    got = {if1.ovf, if1.cout, if1.sum};
`else
    got = {1'b0, if1.cout, if1.sum};
`endif
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    total++;
    if ({if1.in_ready, if1.out_valid, if1.busy, if1.cout, if1.sum} !== 12'h0) begin
      bad++; $display("FAIL reset_state: got rdy/vld/busy/cout/sum=%h want 000", {if1.in_ready, if1.out_valid, if1.busy, if1.cout, if1.sum});
    end
    rst = 1'b0; #1;
    total++;
    if (if1.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release: in_ready=%b/%b want 1", if1.in_ready, if4.in_ready);
    end
  endtask

  // Runs one op through dut1 and checks result + latency against the model.
  task automatic check_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic s, input logic poke);
    int w, lat, rb; logic seen; logic [9:0] got, exp;
    drive_op(a, b, ci, s, poke, w, lat, seen, got, rb);
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s_timeout: no out_valid (wait=%0d lat=%0d)", nm, w, lat);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    exp = sb.pop_front();
    if ((got & MASK) !== (exp & MASK)) begin
      bad++; $display("FAIL %s_result: got %h want %h", nm, got & MASK, exp & MASK);
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL %s_latency: got %0d want 8", nm, lat); end
    total++;
    if (rb !== 0) begin bad++; $display("FAIL %s_run_flags: %0d bad RUN cycles want 0", nm, rb); end
  endtask

  task automatic test_wrap;
    check_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_no_accept;
    check_op("busy", 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin
      bad++; $display("FAIL busy_return: rdy=%b vld=%b want 1/0", if1.in_ready, if1.out_valid);
    end
  endtask

  task automatic test_digit4;
    int lat; logic [9:0] exp; logic [8:0] held;
    if4.out_ready = 1'b0;
    if4.a = 8'h3C; if4.b = 8'h0F; if4.cin = 1'b0; if4.in_valid = 1'b1;
    total++;
    if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL d4_ready: got %b want 1", if4.in_ready); end
    sb.push_back(model(8'h3C, 8'h0F, 1'b0, 1'b0));
    @(negedge clk); if4.in_valid = 1'b0; if4.a = 8'hFF; if4.b = 8'hFF;
    lat = 0;
    while (if4.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    exp = sb.pop_front();
    total++;
    if (lat !== 2) begin bad++; $display("FAIL d4_latency: got %0d want 2", lat); end
    total++;
    if ({if4.cout, if4.sum} !== exp[8:0]) begin
      bad++; $display("FAIL d4_result: got %h want %h", {if4.cout, if4.sum}, exp[8:0]);
    end
    held = {if4.cout, if4.sum};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({if4.out_valid, if4.cout, if4.sum} !== {1'b1, exp[8:0]}) begin
        bad++; $display("FAIL d4_hold: got %h want %h", {if4.out_valid, if4.cout, if4.sum}, {1'b1, exp[8:0]});
      end
    end
    if4.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({if4.in_ready, if4.out_valid, if4.cout, if4.sum} !== {2'b10, held}) begin
      bad++; $display("FAIL d4_release: got %h want %h", {if4.in_ready, if4.out_valid, if4.cout, if4.sum}, {2'b10, held});
    end
  endtask

  task automatic test_reset_mid_run;
    logic saw_vld;
    if1.a = 8'hFF; if1.b = 8'hFF; if1.cin = 1'b1; if1.in_valid = 1'b1;
    @(negedge clk); if1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({if1.in_ready, if1.out_valid, if1.busy} !== 3'b000) begin
      bad++; $display("FAIL midrst_during: rdy/vld/busy=%b want 000", {if1.in_ready, if1.out_valid, if1.busy});
    end
    rst = 1'b0; #1;
    total++;
    if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", if1.in_ready); end
    saw_vld = 1'b0;
    repeat (12) begin @(negedge clk); if (if1.out_valid === 1'b1) saw_vld = 1'b1; end
    total++;
    if (saw_vld !== 1'b0) begin bad++; $display("FAIL midrst_no_valid: out_valid seen=%b want 0", saw_vld); end
    check_op("midrst_next", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef SERIAL_ADDER_SUBTRACT_EN
  task automatic test_subtract;
    check_op("sub_neg", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    check_op("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    check_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_back_to_back;
    int w, lat, rb; logic seen; logic [9:0] got, exp;
    logic [7:0] a, b; logic ci, s;
    int nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
`ifdef SERIAL_ADDER_SUBTRACT_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      drive_op(a, b, ci, s, 1'b0, w, lat, seen, got, rb);
      total++;
      if (!seen) begin
        bad++; nbad++;
        $display("FAIL b2b_timeout: op %0d no out_valid", i);
        if (sb.size() > 0) void'(sb.pop_front());
        if (nbad > 10) break;
        continue;
      end
      exp = sb.pop_front();
      if ((got & MASK) !== (exp & MASK) || lat !== 8 || (i > 0 && w !== 1)) begin
        bad++; nbad++;
        $display("FAIL b2b_op%0d: a=%h b=%h ci=%b s=%b got %h lat=%0d wait=%0d want %h lat=8 wait=1",
                 i, a, b, ci, s, got & MASK, lat, w, exp & MASK);
        if (nbad > 10) break;
      end
    end
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    if1.sub = 1'b0; if4.sub = 1'b0;
`endif
    test_reset();
    test_wrap();
    test_busy_no_accept();
    test_digit4();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUBTRACT_EN
    test_subtract();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
